fc_result_reader: RTL and testbench

FC_RESULT_READER -- requirements
Module: fc_result_reader

---
 rtl/fc_result_reader.sv | 113 +++++++++++
 tb/tb_fc_result_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_reader.sv
// fc_result_reader: streams the fc output buffer out over AXI-stream through a credit-limited FIFO
// and tracks the argmax of each pass.
module fc_result_reader #(
    parameter int OUTPUT_DIM = 128,
    parameter int DATA_W     = 18,
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o,
    output logic [ADDR_W-1:0] argmax_idx_o,
    output logic [DATA_W-1:0] argmax_val_o,
    output logic              argmax_valid_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(OUTPUT_DIM - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, push_idx_q;
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              push, pop, issue, accept;
    int                occ;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign m_tvalid_o = (cnt_q != '0);
    assign {m_tlast_o, m_tdata_o} = m_tvalid_o ? mem[rd_ptr_q] : '0;
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    // Every issued read owns a FIFO slot until popped; a same-cycle pop frees one
    // slot early so a full-rate stream never stalls the read side.
    always_comb begin
        push    = vld_q[RD_LAT-1];
        pop     = m_tvalid_o && m_tready_i;
        accept  = (state_q == IDLE) && start_i;
        occ     = int'(rd_en_o) + $countones(vld_q) + int'(cnt_q);
        issue   = (state_q == READ) && (occ < FIFO_DEPTH + int'(pop));
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (OUTPUT_DIM == 1) ? DRAIN : READ;
            READ:    if (issue && next_addr_q == LAST) state_d = DRAIN;
            DRAIN:   if (pop && m_tlast_o) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            vld_q          <= '0;
            rd_en_o        <= 1'b0;
            rd_addr_o      <= '0;
            next_addr_q    <= '0;
            push_idx_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            argmax_idx_o   <= '0;
            argmax_val_o   <= '0;
            argmax_valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= (vld_q << 1) | RD_LAT'(rd_en_o);
            rd_en_o <= accept || issue;
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            if (pop) rd_ptr_q <= inc(rd_ptr_q);
            if (push) begin
                wr_ptr_q   <= inc(wr_ptr_q);
                push_idx_q <= push_idx_q + 1'b1;
                if (push_idx_q == '0 || rd_data_i > argmax_val_o) begin
                    argmax_val_o <= rd_data_i;
                    argmax_idx_o <= push_idx_q;
                end
            end
            if (accept) begin
                rd_addr_o      <= '0;
                next_addr_q    <= ADDR_W'(1);
                push_idx_q     <= '0;
                argmax_idx_o   <= '0;
                argmax_val_o   <= '0;
                argmax_valid_o <= 1'b0;
            end else if (issue) begin
                rd_addr_o   <= next_addr_q;
                next_addr_q <= next_addr_q + 1'b1;
            end
            if (state_q == DRAIN && state_d == DONE) argmax_valid_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {push_idx_q == LAST, rd_data_i};
    end
endmodule

// File: tb/tb_fc_result_reader.sv
// tb_fc_result_reader: scoreboard bench for fc_result_reader with a RD_LAT-cycle RAM model.
module tb_fc_result_reader;
    localparam int N  = 128;
    localparam int DW = 18;
    localparam int AW = 7;
    localparam int RL = 3;

    logic          clk_i = 0, rst_n_i = 1, start_i = 0, m_tready_i = 1;
    logic          busy_o, done_o, rd_en_o, m_tvalid_o, m_tlast_o, argmax_valid_o;
    logic [AW-1:0] rd_addr_o, argmax_idx_o;
    logic [DW-1:0] rd_data_i, m_tdata_o, argmax_val_o;

    fc_result_reader dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
        .argmax_idx_o(argmax_idx_o), .argmax_val_o(argmax_val_o), .argmax_valid_o(argmax_valid_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] ram [N];
    logic [RL-1:0] p_en = '0;
    logic [AW-1:0] p_addr [RL];
    always @(posedge clk_i) begin
        p_en <= {p_en[RL-2:0], rd_en_o};
        p_addr[0] <= rd_addr_o;
        for (int i = 1; i < RL; i++) p_addr[i] <= p_addr[i-1];
    end
    assign rd_data_i = p_en[RL-1] ? ram[p_addr[RL-1]] : '0;

    int total = 0, bad = 0, cyc = 0;
    int beats, first_cyc, last_cyc, done_cnt = 0, rd_cnt, start_cyc, done_rel, rdy_mode = 1;
    int ref_idx, ref_val;
    logic [AW-1:0] exp_addr;
    logic [DW:0]   exp_q [$];

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (m_tvalid_o && m_tready_i) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: unexpected beat data %0d, want none", m_tdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {13'd0, m_tlast_o, m_tdata_o}, {13'd0, e});
                    end
                    if (beats == 0) first_cyc = cyc;
                    if (m_tlast_o) last_cyc = cyc;
                    beats++;
                end
                if (rd_en_o) begin
                    chk("rd_addr", {25'd0, rd_addr_o}, {25'd0, exp_addr});
                    exp_addr++;
                    rd_cnt++;
                end
                if (done_o) done_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        if (rdy_mode == 2) m_tready_i = 1'($urandom_range(0, 1));
    end

    task automatic load(input int kind);
        for (int i = 0; i < N; i++)
            ram[i] = (kind == 0) ? DW'(i * 3) : (kind == 1) ? DW'((i * 37) % 200) :
                     (kind == 2) ? DW'(10) : (kind == 3) ? ((i == 64) ? DW'(131073) : DW'(5)) :
                     DW'(1000 - i * 5);
    endtask

    task automatic arm();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({i == N - 1, ram[i]});
            if (i == 0 || int'(ram[i]) > ref_val) begin
                ref_val = int'(ram[i]);
                ref_idx = i;
            end
        end
        beats = 0;
        rd_cnt = 0;
        exp_addr = '0;
    endtask

    task automatic go();
        @(posedge clk_i);
        #1;
        start_i = 1;
        start_cyc = cyc;
        @(posedge clk_i);
        #1;
        start_i = 0;
    endtask

    task automatic wait_done(input bit repulse);
        done_rel = -1;
        for (int n = 2; n < 4000 && done_rel < 0; n++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_rel = cyc - start_cyc;
            end else begin
                @(posedge clk_i);
                #1;
                start_i = repulse && (n == 10 || n == 30);
            end
        end
        if (done_rel < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: no done_o, want done within 4000 cycles");
        end
        start_i = 0;
    endtask

    task automatic finish_pass(input string name, input int d0);
        chk({name, "_valid_at_done"}, 32'(argmax_valid_o), 1);
        repeat (5) @(negedge clk_i);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_left_in_queue"}, exp_q.size(), 0);
        chk({name, "_beats"}, beats, N);
        chk({name, "_busy_after"}, 32'(busy_o), 0);
        chk({name, "_argmax_idx"}, 32'(argmax_idx_o), ref_idx);
        chk({name, "_argmax_val"}, 32'(argmax_val_o), ref_val);
    endtask

    task automatic run(input bit repulse, input string name);
        int d0;
        arm();
        d0 = done_cnt;
        go();
        wait_done(repulse);
        finish_pass(name, d0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 32'(busy_o), 0);
        chk({name, "_done"}, 32'(done_o), 0);
        chk({name, "_rd_en"}, 32'(rd_en_o), 0);
        chk({name, "_rd_addr"}, 32'(rd_addr_o), 0);
        chk({name, "_tvalid"}, 32'(m_tvalid_o), 0);
        chk({name, "_tdata"}, 32'(m_tdata_o), 0);
        chk({name, "_tlast"}, 32'(m_tlast_o), 0);
        chk({name, "_am_idx"}, 32'(argmax_idx_o), 0);
        chk({name, "_am_val"}, 32'(argmax_val_o), 0);
        chk({name, "_am_valid"}, 32'(argmax_valid_o), 0);
    endtask

    initial begin
        int d0, b0;
        #2 rst_n_i = 0;
        #1 chk_zero("reset");
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1;

        load(0);
        run(0, "ramp");
        chk("ramp_first_beat_cyc", first_cyc - start_cyc, 5);
        chk("ramp_tlast_cyc", last_cyc - start_cyc, N + 4);
        chk("ramp_done_cyc", done_rel, N + 5);
        chk("ramp_reads", rd_cnt, N);
        chk("ramp_idx_const", 32'(argmax_idx_o), 127);
        chk("ramp_val_const", 32'(argmax_val_o), 381);

        load(4);
        arm();
        d0 = done_cnt;
        rdy_mode = 0;
        m_tready_i = 0;
        go();
        repeat (20) @(negedge clk_i);
        chk("stall_reads", rd_cnt, 5);
        chk("stall_last_addr", 32'(rd_addr_o), 4);
        chk("stall_tvalid", 32'(m_tvalid_o), 1);
        chk("stall_tdata", 32'(m_tdata_o), 1000);
        chk("stall_tlast", 32'(m_tlast_o), 0);
        @(posedge clk_i);
        #1 m_tready_i = 1;
        rdy_mode = 1;
        wait_done(0);
        finish_pass("stall", d0);
        chk("stall_reads_total", rd_cnt, N);

        load(1);
        rdy_mode = 2;
        run(0, "rand");
        rdy_mode = 1;
        @(posedge clk_i);
        #1 m_tready_i = 1;
        chk("rand_idx_const", 32'(argmax_idx_o), 27);
        chk("rand_val_const", 32'(argmax_val_o), 199);

        load(2);
        run(0, "flat");
        chk("flat_idx_const", 32'(argmax_idx_o), 0);
        chk("flat_val_const", 32'(argmax_val_o), 10);

        load(3);
        run(0, "peak");
        chk("peak_idx_const", 32'(argmax_idx_o), 64);
        chk("peak_val_const", 32'(argmax_val_o), 131073);

        load(0);
        run(1, "repulse");

        load(1);
        arm();
        d0 = done_cnt;
        go();
        repeat (49) @(posedge clk_i);
        #1 rst_n_i = 0;
        exp_q.delete();
        #1 chk_zero("midreset");
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1;
        b0 = beats;
        repeat (40) @(negedge clk_i);
        chk("midreset_no_beats", beats - b0, 0);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_idle", 32'(busy_o), 0);
        run(0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
